// File: rtl/traffic_pkg.sv
// Shared encodings and default interval lengths for the traffic-light interval timer.
package traffic_pkg;

  typedef enum logic [1:0] {
    INT_BASE = 2'b00,
    INT_EXT  = 2'b01,
    INT_YEL  = 2'b10,
    INT_RSVD = 2'b11
  } interval_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  localparam int DEF_BASE_SEC = 6;
  localparam int DEF_EXT_SEC  = 3;
  localparam int DEF_YEL_SEC  = 2;

  // A zero-length interval would never expire cleanly, so it is promoted to one second.
  function automatic logic [3:0] sanitize_seconds(input logic [3:0] value);
    return (value == 4'd0) ? 4'd1 : value;
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// Free-running divider producing a one-cycle tick every TICKS_PER_SEC clocks; clear restarts the second.
module one_hz_divider #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clear || count == LAST) count <= '0;
    else                                 count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light FSM: loads a programmable number of seconds and pulses Expired at the end.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int DEFAULT_BASE  = DEF_BASE_SEC,
  parameter int DEFAULT_EXT   = DEF_EXT_SEC,
  parameter int DEFAULT_YEL   = DEF_YEL_SEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start_Timer,
  input  logic [1:0] Interval,
  input  logic       Reprogram,
  input  logic [1:0] Time_Parameter_Selector,
  input  logic [3:0] Time_Value,
  output logic       Expired,
  output logic [3:0] Remaining,
  output logic       One_Hz_Enable
);

  localparam logic [3:0] BASE_RESET = 4'(DEFAULT_BASE);
  localparam logic [3:0] EXT_RESET  = 4'(DEFAULT_EXT);
  localparam logic [3:0] YEL_RESET  = 4'(DEFAULT_YEL);

  state_e     state, state_next;
  logic [3:0] base_sec, ext_sec, yel_sec;
  logic [3:0] load_value, remaining_next;
  logic       expired_next;

  // Starting an interval also restarts the second, so the first second is full length.
  one_hz_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_divider (
    .clock(clock),
    .reset(reset),
    .clear(Start_Timer),
    .tick (One_Hz_Enable)
  );

  // NOTE: these are three plain registers rather than a memory, so they take the reset like any other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_sec <= BASE_RESET;
      ext_sec  <= EXT_RESET;
      yel_sec  <= YEL_RESET;
    end else if (Reprogram) begin
      case (interval_e'(Time_Parameter_Selector))
        INT_BASE: base_sec <= sanitize_seconds(Time_Value);
        INT_EXT:  ext_sec  <= sanitize_seconds(Time_Value);
        INT_YEL:  yel_sec  <= sanitize_seconds(Time_Value);
        default:  ;
      endcase
    end
  end

  // The reserved select falls back to the base interval.
  always_comb begin
    case (interval_e'(Interval))
      INT_EXT: load_value = ext_sec;
      INT_YEL: load_value = yel_sec;
      default: load_value = base_sec;
    endcase
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    remaining_next = Remaining;
    expired_next   = 1'b0;
    if (Start_Timer) begin
      state_next     = ST_COUNTING;
      remaining_next = load_value;
    end else if (state == ST_COUNTING && One_Hz_Enable) begin
      if (Remaining > 4'd1) begin
        remaining_next = Remaining - 4'd1;
      end else begin
        remaining_next = 4'd0;
        expired_next   = 1'b1;
        state_next     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      Remaining <= 4'd0;
      Expired   <= 1'b0;
    end else begin
      state     <= state_next;
      Remaining <= remaining_next;
      Expired   <= expired_next;
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer with a four-cycle second; expected values are hand-computed.
module tb_traffic_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       Start_Timer;
  logic [1:0] Interval;
  logic       Reprogram;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic       Expired;
  logic [3:0] Remaining;
  logic       One_Hz_Enable;

  int n_compared   = 0;
  int n_mismatched = 0;

  traffic_timer #(
    .TICKS_PER_SEC(4),
    .DEFAULT_BASE (6),
    .DEFAULT_EXT  (3),
    .DEFAULT_YEL  (2)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .Start_Timer            (Start_Timer),
    .Interval               (Interval),
    .Reprogram              (Reprogram),
    .Time_Parameter_Selector(Time_Parameter_Selector),
    .Time_Value             (Time_Value),
    .Expired                (Expired),
    .Remaining              (Remaining),
    .One_Hz_Enable          (One_Hz_Enable)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // One rising edge, then sample/drive 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start edge k is the next edge; returns just after it.
  task automatic start(input logic [1:0] iv);
    Start_Timer = 1'b1;
    Interval    = iv;
    step();
    Start_Timer = 1'b0;
  endtask

  task automatic write_param(input logic [1:0] sel, input logic [3:0] value);
    Reprogram               = 1'b1;
    Time_Parameter_Selector = sel;
    Time_Value              = value;
    step();
    Reprogram = 1'b0;
  endtask

  // Steps up to limit edges; reports the edge index of the first Expired pulse (-1 if none) and the pulse count.
  task automatic run_to_expiry(input int limit, output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int j = 1; j <= limit; j++) begin
      step();
      if (Expired === 1'b1) begin
        if (pulses == 0) first = j;
        pulses++;
      end
    end
  endtask

  task automatic test_reset();
    reset                   = 1'b1;
    Start_Timer             = 1'b0;
    Interval                = 2'b00;
    Reprogram               = 1'b0;
    Time_Parameter_Selector = 2'b00;
    Time_Value              = 4'd0;
    repeat (3) step();
    n_compared++;
    if (Remaining !== 4'd0) begin
      n_mismatched++;
      $display("FAIL reset_remaining: got %0d want 0", Remaining);
    end
    n_compared++;
    if (Expired !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_expired: got %b want 0", Expired);
    end
    n_compared++;
    if (One_Hz_Enable !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_tick: got %b want 0", One_Hz_Enable);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_base();
    logic [3:0] exp_rem;
    logic       exp_exp;
    logic       exp_tick;
    start(2'b00);
    n_compared++;
    if (Remaining !== 4'd6) begin
      n_mismatched++;
      $display("FAIL base_load: got %0d want 6", Remaining);
    end
    for (int j = 1; j <= 28; j++) begin
      step();
      exp_rem  = (j >= 24) ? 4'd0 : 4'(6 - j / 4);
      exp_exp  = (j == 24);
      exp_tick = ((j % 4) == 3);
      n_compared++;
      if (Remaining !== exp_rem) begin
        n_mismatched++;
        $display("FAIL base_remaining j=%0d: got %0d want %0d", j, Remaining, exp_rem);
      end
      n_compared++;
      if (Expired !== exp_exp) begin
        n_mismatched++;
        $display("FAIL base_expired j=%0d: got %b want %b", j, Expired, exp_exp);
      end
      n_compared++;
      if (One_Hz_Enable !== exp_tick) begin
        n_mismatched++;
        $display("FAIL base_tick j=%0d: got %b want %b", j, One_Hz_Enable, exp_tick);
      end
    end
  endtask

  task automatic test_restart();
    int first, pulses;
    start(2'b10);
    repeat (4) step();
    n_compared++;
    if (Remaining !== 4'd1) begin
      n_mismatched++;
      $display("FAIL restart_yellow_mid: got %0d want 1", Remaining);
    end
    start(2'b01);
    n_compared++;
    if (Remaining !== 4'd3) begin
      n_mismatched++;
      $display("FAIL restart_ext_load: got %0d want 3", Remaining);
    end
    run_to_expiry(20, first, pulses);
    n_compared++;
    if (first !== 12) begin
      n_mismatched++;
      $display("FAIL restart_expiry_edge: got %0d want 12", first);
    end
    n_compared++;
    if (pulses !== 1) begin
      n_mismatched++;
      $display("FAIL restart_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reprogram();
    int first, pulses;
    write_param(2'b01, 4'd9);
    start(2'b01);
    n_compared++;
    if (Remaining !== 4'd9) begin
      n_mismatched++;
      $display("FAIL reprog_ext_load: got %0d want 9", Remaining);
    end
    // A write during the count must not disturb the running interval.
    write_param(2'b01, 4'd5);
    n_compared++;
    if (Remaining !== 4'd9) begin
      n_mismatched++;
      $display("FAIL reprog_while_counting: got %0d want 9", Remaining);
    end
    run_to_expiry(40, first, pulses);
    n_compared++;
    if (first !== 35) begin
      n_mismatched++;
      $display("FAIL reprog_ext9_expiry: got %0d want 35 after write edge (36 after start)", first);
    end
    write_param(2'b01, 4'd0);
    start(2'b01);
    run_to_expiry(8, first, pulses);
    n_compared++;
    if (first !== 4) begin
      n_mismatched++;
      $display("FAIL reprog_zero_expiry: got %0d want 4", first);
    end
    // Write and start to the same parameter on one edge: old value loads.
    Reprogram               = 1'b1;
    Time_Parameter_Selector = 2'b00;
    Time_Value              = 4'd2;
    start(2'b00);
    Reprogram = 1'b0;
    n_compared++;
    if (Remaining !== 4'd6) begin
      n_mismatched++;
      $display("FAIL reprog_same_edge_old: got %0d want 6", Remaining);
    end
    start(2'b00);
    n_compared++;
    if (Remaining !== 4'd2) begin
      n_mismatched++;
      $display("FAIL reprog_next_start_new: got %0d want 2", Remaining);
    end
    run_to_expiry(12, first, pulses);
    n_compared++;
    if (first !== 8 || pulses !== 1) begin
      n_mismatched++;
      $display("FAIL reprog_base2_expiry: got edge %0d pulses %0d want edge 8 pulses 1", first, pulses);
    end
  endtask

  task automatic test_expiry_restart();
    int first, pulses;
    start(2'b10);
    repeat (7) step();
    n_compared++;
    if (Remaining !== 4'd1 || One_Hz_Enable !== 1'b1) begin
      n_mismatched++;
      $display("FAIL collide_pre: got rem %0d tick %b want rem 1 tick 1", Remaining, One_Hz_Enable);
    end
    start(2'b10);
    n_compared++;
    if (Expired !== 1'b0) begin
      n_mismatched++;
      $display("FAIL collide_expired: got %b want 0", Expired);
    end
    n_compared++;
    if (Remaining !== 4'd2) begin
      n_mismatched++;
      $display("FAIL collide_reload: got %0d want 2", Remaining);
    end
    run_to_expiry(12, first, pulses);
    n_compared++;
    if (first !== 8 || pulses !== 1) begin
      n_mismatched++;
      $display("FAIL collide_expiry: got edge %0d pulses %0d want edge 8 pulses 1", first, pulses);
    end
  endtask

  task automatic test_reset_midcount();
    int first, pulses;
    start(2'b00);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_compared++;
    if (Remaining !== 4'd0 || Expired !== 1'b0 || One_Hz_Enable !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midreset_state: got rem %0d exp %b tick %b want 0 0 0", Remaining, Expired, One_Hz_Enable);
    end
    run_to_expiry(12, first, pulses);
    n_compared++;
    if (pulses !== 0) begin
      n_mismatched++;
      $display("FAIL midreset_no_pulse: got %0d pulses want 0", pulses);
    end
    start(2'b00);
    n_compared++;
    if (Remaining !== 4'd6) begin
      n_mismatched++;
      $display("FAIL midreset_default_base: got %0d want 6", Remaining);
    end
    run_to_expiry(28, first, pulses);
    n_compared++;
    if (first !== 24 || pulses !== 1) begin
      n_mismatched++;
      $display("FAIL midreset_expiry: got edge %0d pulses %0d want edge 24 pulses 1", first, pulses);
    end
  endtask

  task automatic test_reserved();
    int first, pulses;
    start(2'b11);
    n_compared++;
    if (Remaining !== 4'd6) begin
      n_mismatched++;
      $display("FAIL reserved_load: got %0d want 6", Remaining);
    end
    run_to_expiry(28, first, pulses);
    n_compared++;
    if (first !== 24 || pulses !== 1) begin
      n_mismatched++;
      $display("FAIL reserved_expiry: got edge %0d pulses %0d want edge 24 pulses 1", first, pulses);
    end
    write_param(2'b11, 4'd9);
    start(2'b00);
    n_compared++;
    if (Remaining !== 4'd6) begin
      n_mismatched++;
      $display("FAIL reserved_write_base: got %0d want 6", Remaining);
    end
    start(2'b01);
    n_compared++;
    if (Remaining !== 4'd3) begin
      n_mismatched++;
      $display("FAIL reserved_write_ext: got %0d want 3", Remaining);
    end
    start(2'b10);
    n_compared++;
    if (Remaining !== 4'd2) begin
      n_mismatched++;
      $display("FAIL reserved_write_yel: got %0d want 2", Remaining);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_restart();
    test_reprogram();
    test_expiry_restart();
    test_reset_midcount();
    test_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 The block SHALL have the parameter TICKS_PER_SEC, default 100000000, giving the clock cycles per one-second tick.
REQ-002 The block SHALL have the parameter DEFAULT_BASE, default 6, giving the reset value in seconds of the base interval.
REQ-003 The block SHALL have the parameter DEFAULT_EXT, default 3, giving the reset value in seconds of the extended interval.
REQ-004 The block SHALL have the parameter DEFAULT_YEL, default 2, giving the reset value in seconds of the yellow interval.
REQ-005 The block SHALL have the port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have the port Start_Timer, input, 1 bit: starts the selected interval, from the FSM.
REQ-008 The block SHALL have the port Interval, input, 2 bits: interval select (00 base, 01 extended, 10 yellow, 11 reserved).
REQ-009 The block SHALL have the port Reprogram, input, 1 bit: write strobe for the time parameters.
REQ-010 The block SHALL have the port Time_Parameter_Selector, input, 2 bits: the parameter to write, with the same encoding as Interval.
REQ-011 The block SHALL have the port Time_Value, input, 4 bits: the new value in seconds.
REQ-012 The block SHALL have the port Expired, output, 1 bit: a one-cycle pulse at the end of an interval, to the FSM.
REQ-013 The block SHALL have the port Remaining, output, 4 bits: the seconds left, for debug and display.
REQ-014 The block SHALL have the port One_Hz_Enable, output, 1 bit: the one-cycle tick from the divider.

Function
REQ-015 The block SHALL implement two states, IDLE and COUNTING, with registered Expired and Remaining.
REQ-016 The divider SHALL count 0..TICKS_PER_SEC-1, wrap to 0, and assert One_Hz_Enable for the single cycle in which the count equals TICKS_PER_SEC-1.
REQ-017 The block SHALL clear the divider count to 0 on the edge that samples Start_Timer=1, so that the first second is full length.
REQ-018 On Start_Timer=1 in either state, the block SHALL load Remaining with the parameter selected by Interval, enter COUNTING, and treat Interval=11 as 00.
REQ-019 In COUNTING, on each edge where One_Hz_Enable=1 and Remaining>1, Remaining SHALL decrement by 1.
REQ-020 In COUNTING, on the edge where One_Hz_Enable=1 and Remaining==1, the block SHALL set Remaining to 0, set Expired to 1 for exactly one cycle, and return to IDLE.
REQ-021 Expired SHALL therefore be high during the cycle after edge k+N*TICKS_PER_SEC, where k is the start edge and N is the loaded value.
REQ-022 A Start_Timer=1 while COUNTING SHALL restart the interval, and the aborted interval SHALL produce no Expired.
REQ-023 When Start_Timer=1 coincides with the expiry edge, the restart SHALL win and Expired SHALL stay 0.
REQ-024 In IDLE, Remaining SHALL hold 0 and Expired SHALL stay 0.
REQ-025 On Reprogram=1, the block SHALL write Time_Value into the parameter chosen by Time_Parameter_Selector.
REQ-026 A Time_Value of 0 SHALL be stored as 1.
REQ-027 A Reprogram write with Time_Parameter_Selector=11 SHALL be ignored.
REQ-028 A Reprogram write SHALL NOT alter an interval already counting.
REQ-029 When Reprogram and Start_Timer target the same parameter on the same edge, the start SHALL load the old value, and the new value SHALL apply from the next start.
REQ-030 All arithmetic SHALL be unsigned 4-bit; Remaining SHALL never wrap below 0.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set state=IDLE, Remaining=0, Expired=0, divider count=0, and One_Hz_Enable=0.
REQ-032 While reset=1 at an edge, the block SHALL restore the base, extended and yellow parameters to DEFAULT_BASE, DEFAULT_EXT and DEFAULT_YEL.
REQ-033 Reset SHALL take priority over Start_Timer and Reprogram.
REQ-034 Reset during COUNTING SHALL abort the interval with no Expired pulse.

Structure
REQ-035 The shared package traffic_pkg SHALL hold the interval encodings (BASE=00, EXT=01, YEL=10), the state encoding, and the default second values.
REQ-036 The divider SHALL be a sub-module named one_hz_divider (ports clock, reset, clear, tick), parameterised by TICKS_PER_SEC.
REQ-037 The three parameter registers SHALL live inside traffic_timer.

Verification (TICKS_PER_SEC=4)
REQ-038 Scenario: reset, then Start_Timer with Interval=00 at edge k -> Expired=1 only in the cycle after edge k+24, and Remaining steps 6,5,4,3,2,1,0.
REQ-039 Scenario: Start_Timer with Interval=10, then a second Start_Timer with Interval=01 at k+5 -> one Expired only, after edge k+5+12.
REQ-040 Scenario: Reprogram with Selector=01 and Value=9, then start with Interval=01 -> Expired after 36 cycles; Value=0 written gives Expired after 4 cycles.
REQ-041 Scenario: Start_Timer asserted on the expiry edge -> no Expired pulse, and Remaining reloads.
REQ-042 Scenario: reset asserted mid-count -> Remaining=0 and Expired=0 next cycle; a following Interval=00 start takes 24 cycles even after a prior reprogram.
REQ-043 Scenario: Interval=11 -> behaves as base (24 cycles); Reprogram with Selector=11 -> no parameter changes.
